s_inv_transformation: RTL and testbench
=======================================

S_INV_TRANSFORMATION -- requirements
Module: s_inv_transformation

Interface
REQ-001 Parameter RESET_KEY, 8'b10110001, forward S-box active after reset; must be a permutation.
REQ-002 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-003 Rst  input  1  reset, asynchronous, active-high.
REQ-004 Key_load  input  1  request to load Key; sampled only in state IDLE.
REQ-005 Key  input  8  forward S-box: S(v) = Key[7-2v:6-2v], v = 0..3 (symbol 0 in MSBs).
REQ-006 Key_busy  output  1  high while the inverse table is being rebuilt.
REQ-007 Key_err  output  1  high while the last loaded Key is not a permutation.
REQ-008 In_valid  input  1  In_data is valid.
REQ-009 In_data  input  8  ciphered word, four 2-bit symbols, symbol 0 in [7:6].
REQ-010 In_ready  output  1  block accepts a word this cycle.
REQ-011 Out_valid  output  1  Out_data is valid.
REQ-012 Out_data  output  8  deciphered word, same symbol order as In_data.
REQ-013 Out_ready  input  1  sink accepts Out_data this cycle.

Function
REQ-014 The block computes Out symbol i = S^-1(In symbol i) for i = 0..3, inverting the forward 2-bit S-transformation.
REQ-015 FSM states: IDLE, BUILD, SHIFT, HOLD.
REQ-016 IDLE: In_ready = 1 iff key table valid (Key_err = 0); otherwise In_ready = 0.
REQ-017 IDLE with Key_load = 1: capture Key, clear the seen mask, enter BUILD; Key_load has priority over In_valid in the same cycle.
REQ-018 BUILD: 4 cycles, cycle v writes inv[S(v)] = v and sets seen[S(v)]; any repeated S(v) marks the key bad.
REQ-019 BUILD exit: return to IDLE; Key_err = 1 if the key is bad (table invalid), else 0; Key_busy = 1 only in BUILD.
REQ-020 IDLE with In_valid & In_ready: capture In_data into the shift register and enter SHIFT.
REQ-021 SHIFT: 4 cycles, one symbol per cycle, MSB symbol first; the substituted symbol is shifted into the LSBs of the result register.
REQ-022 After the 4th SHIFT edge, enter HOLD with Out_valid = 1; latency from accept edge to Out_valid visible is 5 edges.
REQ-023 HOLD: Out_data and Out_valid are held stable until Out_valid & Out_ready; at that edge go to IDLE and Out_valid = 0.
REQ-024 In_ready = 0 in BUILD, SHIFT and HOLD; throughput is at most one word per 6 cycles.
REQ-025 Key_load outside IDLE is ignored and does not alter a word in flight.
REQ-026 Out_data keeps its last value after the handshake; it is only meaningful while Out_valid = 1.

Reset
REQ-027 Rst = 1 forces IDLE immediately, whatever the current state, including mid-SHIFT or mid-BUILD; in-flight data is discarded.
REQ-028 Reset values: Out_valid = 0, Out_data = 0, Key_busy = 0, Key_err = 0, shift and result registers = 0.
REQ-029 During reset, inv is loaded with the constant inverse of RESET_KEY, so In_ready = 1 in the first cycle after reset release.

Structure
REQ-030 Shared package holds the symbol width (2), symbol count (4), the FSM state encoding, and a constant function for the inverse of an 8-bit key.
REQ-031 One sub-module, s_box_lookup: combinational 4-entry 2-bit table read, instantiated for the inverse table.

Verification
REQ-032 Default key, In_data = 8'b10110100 -> Out_data = 8'b00011110 exactly 5 edges after accept.
REQ-033 Load Key = 8'b00011011 (identity), then In_data = 8'hA5 -> Key_busy high for 4 cycles, then Out_data = 8'hA5.
REQ-034 Load Key = 8'h00 -> Key_err = 1 and In_ready = 0; then load 8'b10110001 -> Key_err = 0 and In_ready = 1.
REQ-035 Out_ready held low for 3 cycles in HOLD -> Out_valid and Out_data stable for those cycles; a single accept on release, then IDLE.
REQ-036 Rst pulsed on the 2nd SHIFT cycle -> Out_valid never asserts for that word; the next word (8'b10110100) gives 8'b00011110.
REQ-037 Key_load and In_valid asserted together in IDLE -> BUILD is entered and the word is not accepted (In_ready low next cycle).

Source files
------------

// File: rtl/s_inv_transformation_pkg.sv
// Shared constants, FSM encoding and key helpers for the inverse 2-bit S-box.
// A key packs four 2-bit symbols, symbol 0 in bits [7:6].
package s_inv_transformation_pkg;

    localparam int SYM_W = 2;
    localparam int SYM_N = 4;
    localparam int WORD_W = SYM_W * SYM_N;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Bit offset of symbol s inside a packed word: symbol 0 sits at [7:6], so lsb = 2*(3-s).
    function automatic logic [2:0] sym_lsb(input logic [SYM_W-1:0] s);
        return {~s, 1'b0};
    endfunction

    function automatic logic [SYM_W-1:0] key_sym(input logic [WORD_W-1:0] key,
                                                 input logic [SYM_W-1:0] v);
        return key[sym_lsb(v) +: SYM_W];
    endfunction

    function automatic logic [WORD_W-1:0] inv_key(input logic [WORD_W-1:0] key);
        logic [WORD_W-1:0] res;
        logic [SYM_W-1:0]  v;
        logic [SYM_W-1:0]  s;
        res = '0;
        for (int i = 0; i < SYM_N; i++) begin
            v = SYM_W'(i);
            s = key_sym(key, v);
            res[sym_lsb(s) +: SYM_W] = v;
        end
        return res;
    endfunction

    function automatic logic is_perm(input logic [WORD_W-1:0] key);
        logic [SYM_N-1:0] seen;
        seen = '0;
        for (int i = 0; i < SYM_N; i++) begin
            seen[key_sym(key, SYM_W'(i))] = 1'b1;
        end
        return &seen;
    endfunction

endpackage

// File: rtl/s_inv_transformation_if.sv
// Key-load, input-word and output-word channels of the inverse S-box block.
// Both data channels use valid/ready: a transfer happens on a rising edge where valid and ready are both high; valid, once raised, holds its data until that edge.
interface s_inv_transformation_if;

    logic       Key_load;
    logic [7:0] Key;
    logic       Key_busy;
    logic       Key_err;
    logic       In_valid;
    logic [7:0] In_data;
    logic       In_ready;
    logic       Out_valid;
    logic [7:0] Out_data;
    logic       Out_ready;

    modport master (
        output Key_load, Key, In_valid, In_data, Out_ready,
        input  Key_busy, Key_err, In_ready, Out_valid, Out_data
    );

    modport slave (
        input  Key_load, Key, In_valid, In_data, Out_ready,
        output Key_busy, Key_err, In_ready, Out_valid, Out_data
    );

endinterface

// File: rtl/s_inv_transformation_s_box_lookup.sv
// Combinational read of a packed 4-entry, 2-bit substitution table.
module s_box_lookup
    import s_inv_transformation_pkg::*;
(
    input  logic [WORD_W-1:0] table_i,
    input  logic [SYM_W-1:0]  sym_i,
    output logic [SYM_W-1:0]  sym_o
);

    assign sym_o = table_i[sym_lsb(sym_i) +: SYM_W];

endmodule

// File: rtl/s_inv_transformation.sv
// Serial inverse 2-bit S-transformation: rebuilds its inverse table from a loaded
// forward key, then substitutes one symbol per cycle of each accepted word.
module s_inv_transformation
    import s_inv_transformation_pkg::*;
#(
    parameter logic [7:0] RESET_KEY = 8'b10110001
)
(
    input  logic                 Clk,
    input  logic                 Rst,
    s_inv_transformation_if.slave bus,
    output state_e               dbg_state_o
);

    localparam logic [WORD_W-1:0] RESET_INV = inv_key(RESET_KEY);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] key_q, key_d;
    logic [WORD_W-1:0] inv_q, inv_d;
    logic [SYM_N-1:0]  seen_q, seen_d;
    logic              bad_q, bad_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] result_q, result_d;

    logic              in_ready;
    logic [SYM_W-1:0]  build_sym;
    logic [SYM_W-1:0]  sub_sym;

    s_box_lookup u_inv_lookup (
        .table_i (inv_q),
        .sym_i   (shift_q[WORD_W-1 -: SYM_W]),
        .sym_o   (sub_sym)
    );

    assign build_sym = key_sym(key_q, cnt_q);
    assign in_ready  = (state_q == ST_IDLE) && !err_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            key_q    <= RESET_KEY;
            inv_q    <= RESET_INV;
            seen_q   <= '0;
            bad_q    <= 1'b0;
            err_q    <= 1'b0;
            shift_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            inv_q    <= inv_d;
            seen_q   <= seen_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            shift_q  <= shift_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        inv_d    = inv_q;
        seen_d   = seen_q;
        bad_d    = bad_q;
        err_d    = err_q;
        shift_d  = shift_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                // A key load wins over a word offered in the same cycle.
                if (bus.Key_load) begin
                    key_d   = bus.Key;
                    seen_d  = '0;
                    bad_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_BUILD;
                end else if (bus.In_valid && in_ready) begin
                    shift_d = bus.In_data;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_BUILD: begin
                inv_d[sym_lsb(build_sym) +: SYM_W] = cnt_q;
                seen_d[build_sym] = 1'b1;
                bad_d = bad_q | seen_q[build_sym];
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    err_d   = bad_d;
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                result_d = {result_q[WORD_W-SYM_W-1:0], sub_sym};
                shift_d  = {shift_q[WORD_W-SYM_W-1:0], {SYM_W{1'b0}}};
                cnt_d    = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.Out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.In_ready  = in_ready;
    assign bus.Key_busy  = (state_q == ST_BUILD);
    assign bus.Key_err   = err_q;
    assign bus.Out_valid = (state_q == ST_HOLD);
    assign bus.Out_data  = result_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_s_inv_transformation.sv
// Directed bench for s_inv_transformation: reset, key rebuild, bad keys,
// backpressure, reset mid-operation, load priority and back-to-back words.
module tb_s_inv_transformation;
    import s_inv_transformation_pkg::*;

    logic   Clk;
    logic   Rst;
    state_e dbg_state;
    int     tests_run;
    int     tests_failed;

    s_inv_transformation_if bus_if ();

    s_inv_transformation #(.RESET_KEY(8'b10110001)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .bus         (bus_if.slave),
        .dbg_state_o (dbg_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_key(input logic [7:0] k);
        bus_if.Key      = k;
        bus_if.Key_load = 1'b1;
        step();
        bus_if.Key_load = 1'b0;
        repeat (4) step();
    endtask

    // Offers one word for a single edge, then runs the four substitution edges.
    task automatic send_word(input logic [7:0] d);
        bus_if.In_data  = d;
        bus_if.In_valid = 1'b1;
        step();
        bus_if.In_valid = 1'b0;
        repeat (4) step();
    endtask

    task automatic release_out();
        bus_if.Out_ready = 1'b1;
        step();
        bus_if.Out_ready = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) step();
        tests_run++;
        if (bus_if.Out_valid !== 1'b0 || bus_if.Out_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_out: valid=%b data=%h expected valid=0 data=00", bus_if.Out_valid, bus_if.Out_data);
        end
        tests_run++;
        if (bus_if.Key_busy !== 1'b0 || bus_if.Key_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_key: busy=%b err=%b expected 0 0", bus_if.Key_busy, bus_if.Key_err);
        end
        Rst = 1'b0;
        step();
        tests_run++;
        if (bus_if.In_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL reset_release: in_ready=%b state=%0d expected 1 IDLE", bus_if.In_ready, dbg_state);
        end
    endtask

    task automatic test_default_word();
        bus_if.In_data  = 8'b10110100;
        bus_if.In_valid = 1'b1;
        step();
        bus_if.In_valid = 1'b0;
        tests_run++;
        if (bus_if.In_ready !== 1'b0 || dbg_state !== ST_SHIFT) begin
            tests_failed++;
            $display("FAIL accept: in_ready=%b state=%0d expected 0 SHIFT", bus_if.In_ready, dbg_state);
        end
        repeat (3) step();
        tests_run++;
        if (bus_if.Out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL early_valid: out_valid=%b after 4 edges expected 0", bus_if.Out_valid);
        end
        step();
        tests_run++;
        if (bus_if.Out_valid !== 1'b1 || bus_if.Out_data !== 8'b00011110) begin
            tests_failed++;
            $display("FAIL default_word: valid=%b data=%b expected 1 00011110", bus_if.Out_valid, bus_if.Out_data);
        end
        release_out();
        tests_run++;
        if (bus_if.Out_valid !== 1'b0 || bus_if.In_ready !== 1'b1 || bus_if.Out_data !== 8'b00011110) begin
            tests_failed++;
            $display("FAIL after_handshake: valid=%b ready=%b data=%b expected 0 1 00011110",
                     bus_if.Out_valid, bus_if.In_ready, bus_if.Out_data);
        end
    endtask

    task automatic test_identity_key();
        int busy_cycles;
        busy_cycles     = 0;
        bus_if.Key      = 8'b00011011;
        bus_if.Key_load = 1'b1;
        step();
        bus_if.Key_load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus_if.Key_busy === 1'b1) busy_cycles++;
            step();
        end
        tests_run++;
        if (busy_cycles != 4) begin
            tests_failed++;
            $display("FAIL busy_len: busy cycles=%0d expected 4", busy_cycles);
        end
        tests_run++;
        if (bus_if.Key_err !== 1'b0 || bus_if.In_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL identity_ok: err=%b ready=%b expected 0 1", bus_if.Key_err, bus_if.In_ready);
        end
        send_word(8'hA5);
        tests_run++;
        if (bus_if.Out_valid !== 1'b1 || bus_if.Out_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL identity_word: valid=%b data=%h expected 1 a5", bus_if.Out_valid, bus_if.Out_data);
        end
        release_out();
    endtask

    task automatic test_bad_key();
        load_key(8'h00);
        tests_run++;
        if (bus_if.Key_err !== 1'b1 || bus_if.In_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bad_key: err=%b ready=%b expected 1 0", bus_if.Key_err, bus_if.In_ready);
        end
        bus_if.In_data  = 8'h5A;
        bus_if.In_valid = 1'b1;
        repeat (3) step();
        bus_if.In_valid = 1'b0;
        tests_run++;
        if (dbg_state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL bad_key_block: state=%0d expected IDLE", dbg_state);
        end
        load_key(8'b10110001);
        tests_run++;
        if (bus_if.Key_err !== 1'b0 || bus_if.In_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL good_key: err=%b ready=%b expected 0 1", bus_if.Key_err, bus_if.In_ready);
        end
    endtask

    task automatic test_hold_backpressure();
        // 8'hE4 = symbols 3,2,1,0 -> inverse 1,0,3,2 = 8'h4E
        send_word(8'hE4);
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (bus_if.Out_valid !== 1'b1 || bus_if.Out_data !== 8'h4E) begin
                tests_failed++;
                $display("FAIL hold_%0d: valid=%b data=%h expected 1 4e", i, bus_if.Out_valid, bus_if.Out_data);
            end
        end
        bus_if.Out_ready = 1'b1;
        step();
        tests_run++;
        if (bus_if.Out_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL hold_release: valid=%b state=%0d expected 0 IDLE", bus_if.Out_valid, dbg_state);
        end
        step();
        bus_if.Out_ready = 1'b0;
        tests_run++;
        if (bus_if.Out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_accept: valid=%b expected 0", bus_if.Out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen_valid;
        seen_valid      = 0;
        bus_if.In_data  = 8'hE4;
        bus_if.In_valid = 1'b1;
        step();
        bus_if.In_valid = 1'b0;
        step();
        Rst = 1'b1;
        #1;
        tests_run++;
        if (dbg_state !== ST_IDLE || bus_if.Out_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL rst_shift: state=%0d data=%h expected IDLE 00", dbg_state, bus_if.Out_data);
        end
        step();
        Rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus_if.Out_valid === 1'b1) seen_valid++;
            step();
        end
        tests_run++;
        if (seen_valid != 0) begin
            tests_failed++;
            $display("FAIL rst_discard: out_valid cycles=%0d expected 0", seen_valid);
        end
        // Reset during a rebuild must restore the default inverse table.
        bus_if.Key      = 8'b00011011;
        bus_if.Key_load = 1'b1;
        step();
        bus_if.Key_load = 1'b0;
        repeat (2) step();
        Rst = 1'b1;
        #1;
        tests_run++;
        if (bus_if.Key_busy !== 1'b0 || bus_if.Key_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_build: busy=%b err=%b expected 0 0", bus_if.Key_busy, bus_if.Key_err);
        end
        step();
        Rst = 1'b0;
        step();
        send_word(8'b10110100);
        tests_run++;
        if (bus_if.Out_valid !== 1'b1 || bus_if.Out_data !== 8'b00011110) begin
            tests_failed++;
            $display("FAIL rst_next_word: valid=%b data=%b expected 1 00011110", bus_if.Out_valid, bus_if.Out_data);
        end
        release_out();
    endtask

    task automatic test_load_priority();
        bus_if.Key      = 8'b10110001;
        bus_if.Key_load = 1'b1;
        bus_if.In_data  = 8'b10110100;
        bus_if.In_valid = 1'b1;
        step();
        bus_if.Key_load = 1'b0;
        bus_if.In_valid = 1'b0;
        tests_run++;
        if (bus_if.Key_busy !== 1'b1 || bus_if.In_ready !== 1'b0 || dbg_state !== ST_BUILD) begin
            tests_failed++;
            $display("FAIL load_priority: busy=%b ready=%b state=%0d expected 1 0 BUILD",
                     bus_if.Key_busy, bus_if.In_ready, dbg_state);
        end
        repeat (6) step();
        tests_run++;
        if (bus_if.Out_valid !== 1'b0 || bus_if.In_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL word_dropped: valid=%b ready=%b expected 0 1", bus_if.Out_valid, bus_if.In_ready);
        end
    endtask

    task automatic test_load_in_flight();
        int busy_seen;
        busy_seen       = 0;
        bus_if.In_data  = 8'b10110100;
        bus_if.In_valid = 1'b1;
        step();
        bus_if.In_valid = 1'b0;
        bus_if.Key      = 8'b00011011;
        bus_if.Key_load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus_if.Key_busy === 1'b1) busy_seen++;
            step();
        end
        bus_if.Key_load = 1'b0;
        tests_run++;
        if (busy_seen != 0 || bus_if.Out_valid !== 1'b1 || bus_if.Out_data !== 8'b00011110) begin
            tests_failed++;
            $display("FAIL load_in_flight: busy=%0d valid=%b data=%b expected 0 1 00011110",
                     busy_seen, bus_if.Out_valid, bus_if.Out_data);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int accepts;
        int outs;
        accepts          = 0;
        outs             = 0;
        bus_if.In_data   = 8'hE4;
        bus_if.In_valid  = 1'b1;
        bus_if.Out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus_if.In_ready === 1'b1) accepts++;
            if (bus_if.Out_valid === 1'b1) begin
                outs++;
                tests_run++;
                if (bus_if.Out_data !== 8'h4E) begin
                    tests_failed++;
                    $display("FAIL b2b_data: data=%h expected 4e", bus_if.Out_data);
                end
            end
            step();
        end
        bus_if.In_valid  = 1'b0;
        bus_if.Out_ready = 1'b0;
        tests_run++;
        if (accepts != 2 || outs != 2) begin
            tests_failed++;
            $display("FAIL b2b_rate: accepts=%0d outputs=%0d expected 2 2", accepts, outs);
        end
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        Rst              = 1'b1;
        bus_if.Key_load  = 1'b0;
        bus_if.Key       = 8'h00;
        bus_if.In_valid  = 1'b0;
        bus_if.In_data   = 8'h00;
        bus_if.Out_ready = 1'b0;
        test_reset();
        test_default_word();
        test_identity_key();
        test_bad_key();
        test_hold_backpressure();
        test_reset_mid_op();
        test_load_priority();
        test_load_in_flight();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
